clock_period_meter: RTL and testbench

- Measures an incoming slow clock, e.g. the divided clock_out of the clock divider, in cycles of the system clock.
- Reports the full period (rising edge to rising edge) and the high time (rising edge to falling edge).
- It is the receiving end of the divider: the divider turns a DIVISOR into a clock, and this block turns a clock back into cycle counts. A divider running on the same clk with DIVISOR=N reads back as period 2N, high time N.
- Used for self-check and bring-up of generated clocks.

---
 rtl/clock_period_meter.sv | 168 ++++++++++++++++
 tb/tb_clock_period_meter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_meter.sv
// Measures period and high time of clk_in in clk cycles.
// Runs continuously: each rise closes one measurement and opens the next.
module clock_period_meter #(
  parameter int CNT_W       = 33,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             clk_in,
  input  logic [CNT_W-1:0] timeout_limit,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   prev_reg;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] high_tmp_reg, high_tmp_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] high_time_reg, high_time_next;
  logic             meas_valid_reg, meas_valid_next;
  logic             timeout_reg, timeout_next;

  logic             sync_bit;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt_inc;
  logic             tmo_hit;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = clk_in;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= sync_next;
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign sync_bit = sync_reg[SYNC_STAGES-1];
  assign rise     = sync_bit & ~prev_reg;
  assign fall     = ~sync_bit & prev_reg;

  // Saturating increment so a stuck input never wraps back to small counts.
  assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_ONE;
  assign tmo_hit = (timeout_limit != '0) && (cnt_reg >= timeout_limit);

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    high_tmp_next   = high_tmp_reg;
    period_next     = period_reg;
    high_time_next  = high_time_reg;
    meas_valid_next = 1'b0;
    timeout_next    = timeout_reg;

    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_next   = '0;
          state_next = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            cnt_next   = CNT_ONE;
            state_next = MEAS_HIGH;
          end else if (tmo_hit) begin
            timeout_next = 1'b1;
            cnt_next     = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        MEAS_HIGH: begin
          // The fall only snapshots cnt; cnt keeps running to the next rise.
          if (fall) begin
            high_tmp_next = cnt_reg;
            cnt_next      = cnt_inc;
            state_next    = MEAS_LOW;
          end else if (tmo_hit) begin
            timeout_next = 1'b1;
            cnt_next     = '0;
            state_next   = WAIT_RISE;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            period_next     = cnt_reg;
            high_time_next  = high_tmp_reg;
            meas_valid_next = 1'b1;
            timeout_next    = 1'b0;
            cnt_next        = CNT_ONE;
            state_next      = MEAS_HIGH;
          end else if (tmo_hit) begin
            timeout_next = 1'b1;
            cnt_next     = '0;
            state_next   = WAIT_RISE;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      high_tmp_reg   <= '0;
      period_reg     <= '0;
      high_time_reg  <= '0;
      meas_valid_reg <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      high_tmp_reg   <= high_tmp_next;
      period_reg     <= period_next;
      high_time_reg  <= high_time_next;
      meas_valid_reg <= meas_valid_next;
      timeout_reg    <= timeout_next;
    end
  end

  assign period     = period_reg;
  assign high_time  = high_time_reg;
  assign meas_valid = meas_valid_reg;
  assign timeout    = timeout_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter: each driven closing rise queues its
// expected period/high time; the monitor pops and compares on meas_valid.
module tb_clock_period_meter;

  localparam int CNT_W = 33;

  typedef struct {
    logic [CNT_W-1:0] p;
    logic [CNT_W-1:0] h;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             clk_in;
  logic [CNT_W-1:0] timeout_limit;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             timeout;
  logic             busy;

  exp_t q[$];
  int   vectors;
  int   miscompares;
  int   cyc;
  int   last_valid_cyc;
  bit   have_last;
  int   exp_gap;

  clock_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .clk_in       (clk_in),
    .timeout_limit(timeout_limit),
    .period       (period),
    .high_time    (high_time),
    .meas_valid   (meas_valid),
    .timeout      (timeout),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: one line per completed measurement.
  always @(negedge clk) begin
    if (!rst && meas_valid) begin
      exp_t e;
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: got period=%0d high=%0d, required no meas_valid", period, high_time);
      end else begin
        e = q.pop_front();
        if (period !== e.p || high_time !== e.h) begin
          miscompares++;
          $display("FAIL measurement: got period=%0d high=%0d, required period=%0d high=%0d",
                   period, high_time, e.p, e.h);
        end else begin
          $display("meas ok: period=%0d high=%0d", period, high_time);
        end
      end
      vectors++;
      if (timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL timeout_at_valid: got %0b, required 0", timeout);
      end
      if (have_last && exp_gap != 0) begin
        vectors++;
        if (cyc - last_valid_cyc != exp_gap) begin
          miscompares++;
          $display("FAIL valid_spacing: got %0d, required %0d", cyc - last_valid_cyc, exp_gap);
        end
      end
      last_valid_cyc = cyc;
      have_last = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // nrise rises of a hi/lo waveform; every rise after the first closes a period.
  task automatic gen(input int hi, input int lo, input int nrise);
    exp_t e;
    for (int i = 1; i <= nrise; i++) begin
      clk_in = 1'b1;
      if (i >= 2) begin
        e.p = CNT_W'(hi + lo);
        e.h = CNT_W'(hi);
        q.push_back(e);
      end
      tick(hi);
      clk_in = 1'b0;
      tick(lo);
    end
  endtask

  task automatic drain(output int left);
    for (int i = 0; i < 40 && q.size() != 0; i++) tick(1);
    left = q.size();
  endtask

  task automatic restart(input logic [CNT_W-1:0] lim);
    enable = 1'b0;
    clk_in = 1'b0;
    exp_gap = 0;
    have_last = 1'b0;
    tick(6);
    timeout_limit = lim;
    enable = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; clk_in = 1'b0; timeout_limit = '0;
    tick(3);
    vectors++;
    if ({period, high_time, meas_valid, timeout, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got p=%0d h=%0d v=%0b t=%0b b=%0b, required all 0",
               period, high_time, meas_valid, timeout, busy);
    end
    rst = 1'b0;
    enable = 1'b1;
    tick(2);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_enabled: got %0b, required 1", busy);
    end
  endtask

  task automatic test_loopback(input int div, input int nrise);
    int left;
    restart('0);
    tick(2);
    exp_gap = 2 * div;
    gen(div, div, nrise);
    drain(left);
    vectors++;
    if (left != 0) begin
      miscompares++;
      $display("FAIL loopback_div%0d_missing: got %0d pending, required 0", div, left);
    end
    exp_gap = 0;
  endtask

  task automatic test_timeout;
    int left;
    restart(CNT_W'(20));
    tick(20);
    vectors++;
    if (timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: got %0b, required 0", timeout);
    end
    tick(2);
    vectors++;
    if (timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_fire: got %0b, required 1", timeout);
    end
    vectors++;
    if (period !== CNT_W'(2)) begin
      miscompares++;
      $display("FAIL timeout_period_held: got %0d, required 2", period);
    end
    tick(45);
    vectors++;
    if (timeout !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_stuck: got t=%0b b=%0b, required t=1 b=1", timeout, busy);
    end
    gen(6, 4, 2);
    drain(left);
    vectors++;
    if (left != 0) begin
      miscompares++;
      $display("FAIL timeout_recovery_missing: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_enable_drop;
    int left;
    restart('0);
    tick(2);
    gen(3, 4, 2);
    drain(left);
    clk_in = 1'b1;
    tick(2);
    enable = 1'b0;
    tick(1);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL enable_drop_busy: got %0b, required 0", busy);
    end
    tick(2);
    vectors++;
    if (period !== CNT_W'(7) || high_time !== CNT_W'(3)) begin
      miscompares++;
      $display("FAIL enable_drop_held: got p=%0d h=%0d, required p=7 h=3", period, high_time);
    end
    enable = 1'b1;
    clk_in = 1'b0;
    tick(6);
    gen(4, 5, 3);
    drain(left);
    vectors++;
    if (left != 0) begin
      miscompares++;
      $display("FAIL enable_drop_missing: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_reset_mid;
    int left;
    restart('0);
    tick(2);
    gen(5, 5, 2);
    #3 rst = 1'b1;
    #1;
    vectors++;
    if ({period, high_time, meas_valid, timeout, busy} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got p=%0d h=%0d v=%0b t=%0b b=%0b, required all 0",
               period, high_time, meas_valid, timeout, busy);
    end
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid_missing: got %0d pending, required 0", q.size());
    end
    @(posedge clk);
    #1 rst = 1'b0;
    gen(5, 5, 3);
    drain(left);
    vectors++;
    if (left != 0) begin
      miscompares++;
      $display("FAIL reset_mid_after_missing: got %0d pending, required 0", left);
    end
  endtask

  task automatic test_tie;
    int left;
    restart(CNT_W'(8));
    gen(4, 4, 5);
    vectors++;
    if (timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL tie_timeout: got %0b, required 0", timeout);
    end
    drain(left);
    vectors++;
    if (left != 0) begin
      miscompares++;
      $display("FAIL tie_missing: got %0d pending, required 0", left);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    last_valid_cyc = 0; have_last = 1'b0; exp_gap = 0;
    rst = 1'b1; enable = 1'b0; clk_in = 1'b0; timeout_limit = '0;
    test_reset();
    test_loopback(5, 6);
    test_loopback(1, 8);
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    test_tie();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
